// File: rtl/pc16_ctrl_if.sv
// Fetch/command bundle between decode, the PC sequencer and instruction memory.
// master = decode/memory side driving commands and fetch_ready; slave = sequencer.
interface pc16_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic             inc;
  logic             call;
  logic             ret;
  logic             clr;
  logic             fetch_ready;
  logic [WIDTH-1:0] out;
  logic             fetch_valid;
  logic             stack_full;
  logic             stack_empty;
  logic             err;

  modport master (
    output in, load, inc, call, ret, clr, fetch_ready,
    input  out, fetch_valid, stack_full, stack_empty, err
  );

  modport slave (
    input  in, load, inc, call, ret, clr, fetch_ready,
    output out, fetch_valid, stack_full, stack_empty, err
  );
endinterface

// File: rtl/pc16_ctrl.sv
// Program-counter sequencer: FETCH presents out until fetch_ready, EXEC applies one command.
// Two cycles minimum per instruction; a stalled fetch holds out and ignores commands.
module pc16_ctrl #(
  parameter int               WIDTH        = 16,
  parameter int               STACK_DEPTH  = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input logic        clk,
  input logic        reset_n,
  pc16_ctrl_if.slave bus
);
  localparam int PW = $clog2(STACK_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(STACK_DEPTH);

  typedef enum logic [1:0] {RST, FETCH, EXEC} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] pc_inc;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [PW-1:0]    top_idx;
  logic             err_q;
  logic             err_nxt;
  logic             push;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] stack [STACK_DEPTH];

  // One shared incrementer feeds inc, the call return address and the over/underflow skip.
  assign pc_inc  = pc + WIDTH'(1);
  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign top_idx = cnt[PW-1:0] - PW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RST:     state_nxt = FETCH;
      FETCH:   if (bus.fetch_ready) state_nxt = EXEC;
      EXEC:    state_nxt = FETCH;
      default: state_nxt = RST;
    endcase
  end

  always_comb begin
    bus.fetch_valid = (state == FETCH);
    bus.out         = pc;
    bus.stack_full  = full;
    bus.stack_empty = empty;
    bus.err         = err_q;
  end

  always_comb begin
    pc_nxt  = pc;
    cnt_nxt = cnt;
    err_nxt = err_q;
    push    = 1'b0;
    if (state == EXEC) begin
      if (bus.clr) begin
        pc_nxt  = RESET_VECTOR;
        cnt_nxt = '0;
        err_nxt = 1'b0;
      end else if (bus.load) begin
        pc_nxt = bus.in;
      end else if (bus.call) begin
        if (!full) begin
          push    = 1'b1;
          cnt_nxt = cnt + CW'(1);
          pc_nxt  = bus.in;
        end else begin
          pc_nxt  = pc_inc;
          err_nxt = 1'b1;
        end
      end else if (bus.ret) begin
        if (!empty) begin
          pc_nxt  = stack[top_idx];
          cnt_nxt = cnt - CW'(1);
        end else begin
          pc_nxt  = pc_inc;
          err_nxt = 1'b1;
        end
      end else if (bus.inc) begin
        pc_nxt = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc    <= RESET_VECTOR;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      pc    <= pc_nxt;
      cnt   <= cnt_nxt;
      err_q <= err_nxt;
    end
  end

  // Entries above the count are dead, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      stack[cnt[PW-1:0]] <= pc_inc;
    end
  end
endmodule

// File: tb/tb_pc16_ctrl.sv
// Directed bench for pc16_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_pc16_ctrl;
  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  pc16_ctrl_if #(.WIDTH(16)) ifc ();

  pc16_ctrl #(.WIDTH(16), .STACK_DEPTH(4), .RESET_VECTOR(16'h0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [15:0] a, input logic l, input logic i,
                         input logic c, input logic r, input logic cl);
    ifc.in   = a;
    ifc.load = l;
    ifc.inc  = i;
    ifc.call = c;
    ifc.ret  = r;
    ifc.clr  = cl;
  endtask

  // Called at a falling edge in FETCH; returns at the falling edge of the next FETCH.
  task automatic instr(input logic [15:0] a, input logic l, input logic i,
                       input logic c, input logic r, input logic cl);
    set_cmd(a, l, i, c, r, cl);
    ifc.fetch_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("exec_fv", {15'd0, ifc.fetch_valid}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    set_cmd(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("fetch_fv", {15'd0, ifc.fetch_valid}, 16'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    ifc.fetch_ready = 1'b0;
    set_cmd(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("rst_out", ifc.out, 16'h0000);
    chk("rst_fv", {15'd0, ifc.fetch_valid}, 16'd0);
    chk("rst_empty", {15'd0, ifc.stack_empty}, 16'd1);
    chk("rst_full", {15'd0, ifc.stack_full}, 16'd0);
    chk("rst_err", {15'd0, ifc.err}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!ifc.fetch_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("first_fetch_fv", {15'd0, ifc.fetch_valid}, 16'd1);
    end
    chk("first_out", ifc.out, 16'h0000);

    instr(16'h0000, 0, 1, 0, 0, 0); chk("inc1", ifc.out, 16'h0001);
    instr(16'h0000, 0, 1, 0, 0, 0); chk("inc2", ifc.out, 16'h0002);
    instr(16'h0000, 0, 1, 0, 0, 0); chk("inc3", ifc.out, 16'h0003);
    instr(16'h0000, 0, 1, 0, 0, 0); chk("inc4", ifc.out, 16'h0004);
    chk("inc_err", {15'd0, ifc.err}, 16'd0);

    instr(16'hFFFF, 1, 0, 0, 0, 0); chk("load_ffff", ifc.out, 16'hFFFF);
    instr(16'h0000, 0, 1, 0, 0, 0); chk("wrap", ifc.out, 16'h0000);
    chk("wrap_empty", {15'd0, ifc.stack_empty}, 16'd1);
    chk("wrap_err", {15'd0, ifc.err}, 16'd0);

    instr(16'h0010, 1, 0, 0, 0, 0); chk("load_0010", ifc.out, 16'h0010);
    instr(16'h0100, 0, 0, 1, 0, 0); chk("call1", ifc.out, 16'h0100);
    chk("call1_empty", {15'd0, ifc.stack_empty}, 16'd0);
    instr(16'h0200, 0, 0, 1, 0, 0); chk("call2", ifc.out, 16'h0200);
    instr(16'h0000, 0, 0, 0, 1, 0); chk("ret1", ifc.out, 16'h0101);
    instr(16'h0000, 0, 0, 0, 1, 0); chk("ret2", ifc.out, 16'h0011);
    chk("ret_empty", {15'd0, ifc.stack_empty}, 16'd1);

    instr(16'h0300, 0, 0, 1, 0, 0); chk("c1", ifc.out, 16'h0300);
    instr(16'h0300, 0, 0, 1, 0, 0); chk("c2", ifc.out, 16'h0300);
    instr(16'h0300, 0, 0, 1, 0, 0); chk("c3_full", {15'd0, ifc.stack_full}, 16'd0);
    instr(16'h0300, 0, 0, 1, 0, 0); chk("c4", ifc.out, 16'h0300);
    chk("c4_full", {15'd0, ifc.stack_full}, 16'd1);
    chk("c4_err", {15'd0, ifc.err}, 16'd0);
    instr(16'h0300, 0, 0, 1, 0, 0); chk("ovf_out", ifc.out, 16'h0301);
    chk("ovf_err", {15'd0, ifc.err}, 16'd1);
    chk("ovf_full", {15'd0, ifc.stack_full}, 16'd1);
    instr(16'h0000, 0, 0, 0, 1, 0); chk("r1", ifc.out, 16'h0301);
    chk("r1_full", {15'd0, ifc.stack_full}, 16'd0);
    instr(16'h0000, 0, 0, 0, 1, 0); chk("r2", ifc.out, 16'h0301);
    instr(16'h0000, 0, 0, 0, 1, 0); chk("r3", ifc.out, 16'h0301);
    instr(16'h0000, 0, 0, 0, 1, 0); chk("r4", ifc.out, 16'h0012);
    chk("r4_empty", {15'd0, ifc.stack_empty}, 16'd1);
    instr(16'h0000, 0, 0, 0, 1, 0); chk("unf_out", ifc.out, 16'h0013);
    chk("unf_err", {15'd0, ifc.err}, 16'd1);
    instr(16'h5555, 1, 1, 1, 1, 1); chk("clr_out", ifc.out, 16'h0000);
    chk("clr_err", {15'd0, ifc.err}, 16'd0);
    chk("clr_empty", {15'd0, ifc.stack_empty}, 16'd1);

    instr(16'h0ABC, 1, 1, 1, 0, 0); chk("prio_out", ifc.out, 16'h0ABC);
    chk("prio_empty", {15'd0, ifc.stack_empty}, 16'd1);

    ifc.fetch_ready = 1'b0;
    set_cmd(16'h1234, 1, 1, 1, 1, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_out", ifc.out, 16'h0ABC);
      chk("stall_fv", {15'd0, ifc.fetch_valid}, 16'd1);
    end
    set_cmd(16'h0000, 0, 0, 0, 0, 0);
    instr(16'h0000, 0, 1, 0, 0, 0); chk("post_stall", ifc.out, 16'h0ABD);
    chk("post_stall_empty", {15'd0, ifc.stack_empty}, 16'd1);

    instr(16'h0000, 0, 0, 0, 1, 0); chk("unf2_out", ifc.out, 16'h0ABE);
    instr(16'h0500, 0, 0, 1, 0, 0); chk("pre_call1", ifc.out, 16'h0500);
    instr(16'h0123, 0, 0, 1, 0, 0); chk("pre_call2", ifc.out, 16'h0123);
    chk("pre_err", {15'd0, ifc.err}, 16'd1);
    ifc.fetch_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out", ifc.out, 16'h0000);
    chk("arst_fv", {15'd0, ifc.fetch_valid}, 16'd0);
    chk("arst_empty", {15'd0, ifc.stack_empty}, 16'd1);
    chk("arst_err", {15'd0, ifc.err}, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rec_fv", {15'd0, ifc.fetch_valid}, 16'd1);
    instr(16'h0000, 0, 1, 0, 0, 0); chk("rec_inc", ifc.out, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
